bus_reg_reader: RTL and testbench

- General-purpose register on the shared 8-bit data bus.
- It is the receiving end of the bus-driver protocol used by the ALU units: it latches whatever a driver (ALU, another register) places on the bus.
- It can drive its own value back onto the bus through a tristate output, and it presents its value continuously to the ALU argument inputs.
- Supports increment/decrement with wrap-around and maintains Z/N/C status plus a sticky bus-conflict flag, so it can also serve as a counter or stack pointer.

---
 rtl/cpu_bus_pkg.sv | 41 ++++
 rtl/bus_reg_flags.sv | 21 ++
 rtl/bus_reg_reader.sv | 91 +++++++++
 tb/tb_bus_reg_reader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for blocks on the 8-bit CPU data bus: bus width,
// request-priority encoding and the register-side state encoding.
package cpu_bus_pkg;

    localparam int BUS_WIDTH = 8;

    // Per-edge request after priority resolution.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC,
        OP_CONFLICT
    } op_t;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_LOAD,
        ST_COUNT,
        ST_FAULT
    } reg_state_t;

    // Resolve the raw strobes into a single request.
    // Load beats counting, and a load against our own bus drive is a conflict.
    function automatic op_t decode_op(
        input logic loadn,
        input logic outn,
        input logic inc,
        input logic dec
    );
        if (!loadn)
            return outn ? OP_LOAD : OP_CONFLICT;
        else if (inc && !dec)
            return OP_INC;
        else if (dec && !inc)
            return OP_DEC;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/bus_reg_flags.sv
// Combinational Z/N/C status from the candidate next value; carry is the
// wrap of an increment from all-ones or of a decrement from zero.
module bus_reg_flags
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH
) (
    input  logic [WIDTH-1:0] cur_value,
    input  logic [WIDTH-1:0] next_value,
    input  op_t              op,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    assign flag_z = (next_value == '0);
    assign flag_n = next_value[WIDTH-1];
    assign flag_c = ((op == OP_INC) && (&cur_value)) ||
                    ((op == OP_DEC) && !(|cur_value));

endmodule

// File: rtl/bus_reg_reader.sv
// General-purpose bus register: latches the shared bus, drives it back via a
// tristate, counts up/down with status flags and a sticky conflict flag.
module bus_reg_reader
    import cpu_bus_pkg::*;
#(
    parameter int               WIDTH     = BUS_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             loadn,
    input  logic             outn,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             conflict
);

    op_t              op;
    reg_state_t       state;
    logic [WIDTH-1:0] next_value;
    logic             nxt_z;
    logic             nxt_n;
    logic             nxt_c;

    // Tristate drive is combinational so the bus tracks value with no latency.
    assign bus = outn ? {WIDTH{1'bz}} : value;

    assign op = decode_op(loadn, outn, inc, dec);

    always_comb begin
        // NOTE: default first so every path assigns next_value and no latch is inferred.
        next_value = value;
        case (op)
            OP_LOAD: next_value = bus;
            OP_INC:  next_value = value + 1'b1;
            OP_DEC:  next_value = value - 1'b1;
            default: next_value = value;
        endcase
    end

    bus_reg_flags #(
        .WIDTH(WIDTH)
    ) u_flags (
        .cur_value (value),
        .next_value(next_value),
        .op        (op),
        .flag_z    (nxt_z),
        .flag_n    (nxt_n),
        .flag_c    (nxt_c)
    );

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            value    <= RESET_VAL;
            flag_z   <= (RESET_VAL == '0);
            flag_n   <= RESET_VAL[WIDTH-1];
            flag_c   <= 1'b0;
            conflict <= 1'b0;
            state    <= ST_HOLD;
        end else begin
            case (op)
                OP_LOAD, OP_INC, OP_DEC: begin
                    // Carry from the flags block is already 0 for a load.
                    value  <= next_value;
                    flag_z <= nxt_z;
                    flag_n <= nxt_n;
                    flag_c <= nxt_c;
                end
                OP_CONFLICT: conflict <= 1'b1;
                default: ;
            endcase

            // FAULT is sticky until reset; it only marks the conflict condition.
            if (state == ST_FAULT || op == OP_CONFLICT)
                state <= ST_FAULT;
            else if (op == OP_LOAD)
                state <= ST_LOAD;
            else if (op == OP_INC || op == OP_DEC)
                state <= ST_COUNT;
            else
                state <= ST_HOLD;
        end
    end

endmodule

// File: tb/tb_bus_reg_reader.sv
// Directed bench for bus_reg_reader: a reference model pushes expected
// register/flag state to a scoreboard queue, popped after each clock edge.
module tb_bus_reg_reader;
    import cpu_bus_pkg::*;

    typedef struct {
        logic [7:0] v;
        logic       z;
        logic       n;
        logic       c;
        logic       cf;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       loadn;
    logic       outn;
    logic       inc;
    logic       dec;
    logic [7:0] value;
    logic       flag_z;
    logic       flag_n;
    logic       flag_c;
    logic       conflict;

    wire  [7:0] bus;
    logic       drv_en;
    logic [7:0] drv_val;

    int vectors     = 0;
    int miscompares = 0;

    exp_t sb[$];

    // Reference model state
    logic [7:0] m_v;
    logic       m_z, m_n, m_c, m_cf;

    always #5 clk = ~clk;

    assign bus = drv_en ? drv_val : 8'bz;

    // Weak pull-ups make a released bus read as all-ones.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (bus[gi]);
    end

    bus_reg_reader #(
        .WIDTH    (8),
        .RESET_VAL(8'h00)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .loadn   (loadn),
        .outn    (outn),
        .inc     (inc),
        .dec     (dec),
        .value   (value),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .flag_c  (flag_c),
        .conflict(conflict)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, model it, then check after the edge.
    task automatic step(input logic rst, input logic ln, input logic on,
                        input logic i, input logic d, input logic de,
                        input logic [7:0] dv, input string tag);
        exp_t e;
        exp_t got;
        reset   = rst;
        loadn   = ln;
        outn    = on;
        inc     = i;
        dec     = d;
        drv_en  = de;
        drv_val = dv;
        #1;
        if (!on)
            cmp({tag, "/bus_pre"}, bus, m_v);
        else if (!de)
            cmp({tag, "/bus_released"}, bus, 8'hFF);

        if (rst) begin
            m_v = 8'h00; m_c = 1'b0; m_cf = 1'b0;
            m_z = 1'b1;  m_n = 1'b0;
        end else if (!ln && on) begin
            m_v = dv; m_c = 1'b0;
            m_z = (m_v == 8'h00); m_n = m_v[7];
        end else if (!ln && !on) begin
            m_cf = 1'b1;
        end else if (i && !d) begin
            m_c = (m_v == 8'hFF);
            m_v = m_v + 8'h01;
            m_z = (m_v == 8'h00); m_n = m_v[7];
        end else if (d && !i) begin
            m_c = (m_v == 8'h00);
            m_v = m_v - 8'h01;
            m_z = (m_v == 8'h00); m_n = m_v[7];
        end
        e = '{v: m_v, z: m_z, n: m_n, c: m_c, cf: m_cf, tag: tag};
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            cmp({got.tag, "/value"},    value,          got.v);
            cmp({got.tag, "/flag_z"},   {7'd0, flag_z}, {7'd0, got.z});
            cmp({got.tag, "/flag_n"},   {7'd0, flag_n}, {7'd0, got.n});
            cmp({got.tag, "/flag_c"},   {7'd0, flag_c}, {7'd0, got.c});
            cmp({got.tag, "/conflict"}, {7'd0, conflict}, {7'd0, got.cf});
            if (!on)
                cmp({got.tag, "/bus_post"}, bus, got.v);
        end
    endtask

    initial begin
        logic [7:0] pat;
        m_v = 8'h00; m_z = 1'b1; m_n = 1'b0; m_c = 1'b0; m_cf = 1'b0;
        reset = 1'b1; loadn = 1'b1; outn = 1'b1; inc = 1'b0; dec = 1'b0;
        drv_en = 1'b0; drv_val = 8'h00;
        @(posedge clk);
        #1;

        // Reset state, bus released
        step(1, 1, 1, 0, 0, 0, 8'h00, "reset");
        cmp("reset/value_const", value, 8'h00);

        // Load A5 from an external driver, then drive it back
        step(0, 0, 1, 0, 0, 1, 8'hA5, "load_a5");
        cmp("load_a5/value_const", value, 8'hA5);
        step(0, 1, 0, 0, 0, 0, 8'h00, "drive_a5");

        // Increment/decrement wrap and carry/borrow
        step(0, 0, 1, 0, 0, 1, 8'hFE, "load_fe");
        step(0, 1, 1, 1, 0, 0, 8'h00, "inc_ff");
        step(0, 1, 1, 1, 0, 0, 8'h00, "inc_wrap");
        cmp("inc_wrap/carry_const", {7'd0, flag_c}, 8'h01);
        step(0, 1, 1, 0, 1, 0, 8'h00, "dec_borrow");
        cmp("dec_borrow/value_const", value, 8'hFF);
        step(0, 1, 1, 0, 1, 0, 8'h00, "dec_fe");

        // Load beats inc; inc+dec together holds
        step(0, 0, 1, 1, 0, 1, 8'h01, "load_over_inc");
        cmp("load_over_inc/value_const", value, 8'h01);
        step(0, 1, 1, 1, 1, 0, 8'h00, "inc_dec_hold");

        // Conflict: load while driving the bus, then sticky until reset
        step(0, 0, 1, 0, 0, 1, 8'h3C, "load_3c");
        step(0, 0, 0, 0, 0, 0, 8'h00, "conflict");
        cmp("conflict/value_const", value, 8'h3C);
        step(0, 0, 1, 0, 0, 1, 8'h55, "load_after_cf");
        step(0, 1, 1, 1, 0, 0, 8'h00, "inc_after_cf");
        step(0, 1, 1, 0, 1, 0, 8'h00, "dec_after_cf");
        step(0, 1, 0, 0, 0, 0, 8'h00, "hold_drive_cf");
        step(1, 1, 1, 0, 0, 0, 8'h00, "reset_clears_cf");

        // Reset mid-sequence dominates a simultaneous load, then resume
        step(0, 1, 1, 1, 0, 0, 8'h00, "inc_before_rst");
        step(1, 0, 1, 1, 0, 1, 8'h77, "rst_over_load");
        step(0, 0, 1, 0, 0, 1, 8'h80, "load_after_rst");

        // Walking one and walking zero through every bit position
        for (int i = 0; i < 8; i++) begin
            pat = 8'h01 << i;
            step(0, 0, 1, 0, 0, 1, pat, $sformatf("walk1_load_%0d", i));
            step(0, 1, 0, 0, 0, 0, 8'h00, $sformatf("walk1_drive_%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            pat = ~(8'h01 << i);
            step(0, 0, 1, 0, 0, 1, pat, $sformatf("walk0_load_%0d", i));
            step(0, 1, 0, 0, 0, 0, 8'h00, $sformatf("walk0_drive_%0d", i));
        end

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
